lib_timer_ctrl: RTL and testbench
=================================

# lib_timer_ctrl

Programmable interval timer controller that drives a `libCOUNTER_max` instance and consumes its overflow flag. A small register port loads the counter's max value, enables counting through a prescaler, and selects periodic or one-shot mode. Each new counter overflow latches a pending flag and raises `irq` when enabled. The block sits between the CPU-side peripheral bus decode and the counter.

## Interface
- `DW`, 16: counter / data width; must match the counter's `DW`.
- `PW`, 8: prescaler width.

- `clk`  in  1  clock.
- `rstn`  in  1  reset, asynchronous, active-low.
- `wr_en`  in  1  register write strobe.
- `addr`  in  3  register address, shared by reads and writes.
- `wr_data`  in  DW  write data.
- `rd_data`  out  DW  combinational read data for `addr`.
- `irq`  out  1  `pending & IE`.
- `cnt_we`  out  1  to counter `we`.
- `cnt_din`  out  DW  to counter `din`; always equals `wr_data`.
- `cnt_ce`  out  1  to counter `ce`.
- `cnt_of`  in  1  from counter `of`.
- `cnt_dout`  in  DW  from counter `dout`.

## Operation
- Registers: `0` CTRL `{IE[2], MODE[1], EN[0]}` (MODE 0 = periodic, 1 = one-shot). `1` LOAD (DW bits). `2` PRESC (PW bits, zero-extended on read). `3` STATUS `{BUSY[1], PENDING[0]}`; write 1 to bit0 clears PENDING. `4` COUNT, read-only, returns `cnt_dout`. Reads of addresses 5–7 return 0; writes to 3 (other than bit0), 4, 5–7 are ignored.
- LOAD write: accepted only while EN=0. When accepted, updates the shadow and asserts `cnt_we` in the same cycle. While EN=1 the write is dropped: no `cnt_we`, shadow unchanged.
- Setting EN=1 while LOAD shadow == 0 is refused: EN stays 0 and IE/MODE update. This prevents the counter from never matching its max.
- FSM states:
  - IDLE: EN=0, `cnt_ce`=0, prescaler held at 0.
  - RUN: entered on an accepted EN 0→1 write.
  - DONE: one-shot has completed.
  - Transitions: RUN→IDLE on EN=0 write. RUN→DONE on an overflow event with MODE=1; hardware clears EN in the same edge. DONE→RUN on EN=1 write. DONE→IDLE on EN=0 write.
- Prescaler: `presc_cnt` counts 0..PRESC in RUN. `tick` = RUN & (`presc_cnt` == PRESC); on tick, `presc_cnt` returns to 0. `cnt_ce` = `tick`. PRESC=0 gives a tick every RUN cycle.
- Overflow event = `cnt_of & ~of_d`, where `of_d` is `cnt_of` registered. An event sets PENDING.
- Event and STATUS clear in the same cycle: set wins.
- Disable mid-run: counter value and `of` are held. Re-enable resumes from the held value; the prescaler restarts at 0.
- Counter period: from counter reset (0), an overflow occurs after LOAD ticks. Every later overflow occurs LOAD+1 ticks after the previous one (the tick out of the overflow state returns the counter to 0).
- Changing PRESC while running takes effect immediately. If `presc_cnt` > new PRESC, it counts up to 2^PW−1, wraps to 0, then continues normally.

## Timing
- Reset values: CTRL=0, LOAD=0, PRESC=0, PENDING=0, `of_d`=0, state IDLE. Resulting outputs: `irq`=0, `cnt_ce`=0, `cnt_we`=0, `rd_data`=0 when `addr`=0.
- All register writes take effect at the `clk` edge that samples `wr_en`.
- EN write at cycle T: RUN at T+1. First `cnt_ce` at T+1+PRESC, then every PRESC+1 cycles.
- `cnt_ce` at cycle C with `dout`+1 == LOAD: `cnt_of`=1 at C+1. PENDING and `irq` are high at C+2. In one-shot, EN=0 and state DONE are also visible at C+2.
- `cnt_we` is combinational with the write strobe. The counter sees the new max from the next cycle.
- Async reset mid-run returns everything to reset values immediately. The external counter must share `rstn`.

## Test plan
- LOAD=3, PRESC=0, MODE=0, IE=1, EN=1 at T → `cnt_ce` high every cycle from T+1; first `irq` at T+5; next overflows every 4 cycles; COUNT reads 0,1,2,3,0….
- LOAD=2, PRESC=1, MODE=1, EN=1 at T → `cnt_ce` at T+2 and T+4; PENDING at T+6; CTRL reads EN=0; STATUS BUSY=0; no further `cnt_ce`.
- Running, write LOAD=7 → `cnt_we` stays 0; LOAD still reads old value. Then EN=0, write LOAD=7 → `cnt_we`=1 for one cycle with `cnt_din`=7.
- LOAD=0, write CTRL=0b001 → EN reads 0, state IDLE, `cnt_ce` never asserted.
- STATUS write 0b1 in the same cycle as an overflow event → PENDING remains 1. A later clear write with no event → PENDING=0, `irq`=0 next cycle.
- Drop `rstn` mid-RUN with PENDING=1 → `irq`, `cnt_ce`, CTRL, LOAD, PRESC all read 0 immediately; after release, the block stays IDLE.

Source files
------------

// File: rtl/lib_timer_ctrl.sv
`timescale 1ns/1ps
// lib_timer_ctrl
// Programmable interval timer controller. Sits between the CPU-side register
// decode and an external max-value counter: it loads the counter's max value,
// gates the counter's count enable through a prescaler, and turns rising edges
// of the counter's overflow flag into a pending flag / interrupt. Periodic and
// one-shot modes are supported.
//
// Parameters
//   DW  counter / data width (must match the counter)
//   PW  prescaler width (PW <= DW, DW >= 3)
//
// Ports
//   clk       in   clock
//   rstn      in   asynchronous active-low reset (shared with the counter)
//   wr_en     in   register write strobe
//   addr      in   register address for reads and writes
//   wr_data   in   write data
//   rd_data   out  combinational read data for addr
//   irq       out  pending & IE
//   cnt_we    out  counter max-value load strobe
//   cnt_din   out  counter max value (always wr_data)
//   cnt_ce    out  counter count enable (prescaler tick)
//   cnt_of    in   counter overflow flag
//   cnt_dout  in   counter current value
//
// Register map
//   0 CTRL   {IE[2], MODE[1], EN[0]}   MODE: 0 periodic, 1 one-shot
//   1 LOAD   counter max value, writable only while EN=0
//   2 PRESC  prescaler reload value (zero-extended on read)
//   3 STATUS {BUSY[1], PENDING[0]}     write 1 to bit0 clears PENDING
//   4 COUNT  read-only counter value
//   5-7      read as zero, writes ignored
module lib_timer_ctrl #(
    parameter int DW = 16,
    parameter int PW = 8
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          wr_en,
    input  logic [2:0]    addr,
    input  logic [DW-1:0] wr_data,
    output logic [DW-1:0] rd_data,
    output logic          irq,
    output logic          cnt_we,
    output logic [DW-1:0] cnt_din,
    output logic          cnt_ce,
    input  logic          cnt_of,
    input  logic [DW-1:0] cnt_dout
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_state_next;
    logic          r_ie;
    logic          r_mode;
    logic [DW-1:0] r_load;
    logic [PW-1:0] r_presc;
    logic [PW-1:0] r_presc_cnt;
    logic          r_pending;
    logic          r_of_d;

    logic w_en;
    logic w_wr_ctrl;
    logic w_wr_load;
    logic w_wr_presc;
    logic w_wr_status;
    logic w_load_nz;
    logic w_tick;
    logic w_of_evt;

    // EN is exactly "state is RUN": IDLE and DONE both read back EN=0.
    assign w_en        = (r_state == S_RUN);
    assign w_wr_ctrl   = wr_en && (addr == 3'd0);
    assign w_wr_load   = wr_en && (addr == 3'd1);
    assign w_wr_presc  = wr_en && (addr == 3'd2);
    assign w_wr_status = wr_en && (addr == 3'd3);
    assign w_load_nz   = (r_load != '0);
    assign w_tick      = w_en && (r_presc_cnt == r_presc);
    assign w_of_evt    = cnt_of && !r_of_d;

    assign cnt_ce  = w_tick;
    assign cnt_din = wr_data;
    // LOAD is frozen while running so the counter's max cannot move under it.
    assign cnt_we  = w_wr_load && !w_en;
    assign irq     = r_pending && r_ie;

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                // Enabling with a zero max would leave the counter never matching.
                if (w_wr_ctrl && wr_data[0] && w_load_nz) begin
                    w_state_next = S_RUN;
                end
            end
            S_RUN: begin
                if (w_wr_ctrl && !wr_data[0]) begin
                    w_state_next = S_IDLE;
                end else if (w_of_evt && r_mode) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                if (w_wr_ctrl) begin
                    if (!wr_data[0]) begin
                        w_state_next = S_IDLE;
                    end else if (w_load_nz) begin
                        w_state_next = S_RUN;
                    end
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // ---------------- registers ----------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_ie      <= 1'b0;
            r_mode    <= 1'b0;
            r_load    <= '0;
            r_presc   <= '0;
            r_pending <= 1'b0;
            r_of_d    <= 1'b0;
        end else begin
            r_of_d <= cnt_of;
            if (w_wr_ctrl) begin
                r_ie   <= wr_data[2];
                r_mode <= wr_data[1];
            end
            if (cnt_we) begin
                r_load <= wr_data;
            end
            if (w_wr_presc) begin
                r_presc <= wr_data[PW-1:0];
            end
            // A new overflow event beats a simultaneous clear.
            if (w_of_evt) begin
                r_pending <= 1'b1;
            end else if (w_wr_status && wr_data[0]) begin
                r_pending <= 1'b0;
            end
        end
    end

    // Prescaler only advances while staying in RUN; any entry into RUN
    // therefore starts from 0. If PRESC drops below the current count it
    // simply runs up to all-ones and wraps.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_presc_cnt <= '0;
        end else if (w_en && (w_state_next == S_RUN)) begin
            r_presc_cnt <= w_tick ? '0 : r_presc_cnt + PW'(1);
        end else begin
            r_presc_cnt <= '0;
        end
    end

    // ---------------- read mux ----------------
    always_comb begin
        rd_data = '0;
        case (addr)
            3'd0: rd_data[2:0]    = {r_ie, r_mode, w_en};
            3'd1: rd_data         = r_load;
            3'd2: rd_data[PW-1:0] = r_presc;
            3'd3: rd_data[1:0]    = {w_en, r_pending};
            3'd4: rd_data         = cnt_dout;
            default: rd_data      = '0;
        endcase
    end

endmodule

// File: tb/tb_lib_timer_ctrl.sv
`timescale 1ns/1ps
module tb_lib_timer_ctrl;
    localparam int DW = 16;
    localparam int PW = 8;

    logic          clk = 1'b0;
    logic          rstn;
    logic          wr_en;
    logic [2:0]    addr;
    logic [DW-1:0] wr_data;
    logic [DW-1:0] rd_data;
    logic          irq;
    logic          cnt_we;
    logic [DW-1:0] cnt_din;
    logic          cnt_ce;
    logic          cnt_of;
    logic [DW-1:0] cnt_dout;

    always #5 clk = ~clk;

    lib_timer_ctrl #(.DW(DW), .PW(PW)) dut (
        .clk      (clk),
        .rstn     (rstn),
        .wr_en    (wr_en),
        .addr     (addr),
        .wr_data  (wr_data),
        .rd_data  (rd_data),
        .irq      (irq),
        .cnt_we   (cnt_we),
        .cnt_din  (cnt_din),
        .cnt_ce   (cnt_ce),
        .cnt_of   (cnt_of),
        .cnt_dout (cnt_dout)
    );

    // Behavioural model of the external max-value counter.
    logic [DW-1:0] c_max, c_dout;
    logic          c_of;
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            c_max  <= '0;
            c_dout <= '0;
            c_of   <= 1'b0;
        end else begin
            if (cnt_we) c_max <= cnt_din;
            if (cnt_ce) begin
                if (c_dout == c_max) begin
                    c_dout <= '0;
                    c_of   <= 1'b0;
                end else begin
                    c_dout <= c_dout + 16'd1;
                    c_of   <= ((c_dout + 16'd1) == c_max);
                end
            end
        end
    end
    assign cnt_of   = c_of;
    assign cnt_dout = c_dout;

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rstn    = 1'b0;
        wr_en   = 1'b0;
        addr    = 3'd0;
        wr_data = '0;
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
    endtask

    task automatic do_wr(input logic [2:0] a, input logic [DW-1:0] d);
        wr_en   = 1'b1;
        addr    = a;
        wr_data = d;
        step();
        wr_en = 1'b0;
    endtask

    task automatic rd_chk(input string name, input logic [2:0] a, input logic [DW-1:0] exp);
        addr = a;
        #1;
        check(name, 32'(rd_data), 32'(exp));
    endtask

    typedef struct {
        logic          wr;
        logic [2:0]    addr;
        logic [DW-1:0] data;
        logic [DW-1:0] exp_rd;
        logic          exp_we;
    } vec_t;

    localparam int NV = 22;
    vec_t vecs [NV];

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        // wr, addr, data, exp_rd, exp_we
        vecs[0]  = '{1'b0, 3'd0, 16'h0000, 16'h0000, 1'b0};
        vecs[1]  = '{1'b0, 3'd1, 16'h0000, 16'h0000, 1'b0};
        vecs[2]  = '{1'b0, 3'd2, 16'h0000, 16'h0000, 1'b0};
        vecs[3]  = '{1'b0, 3'd3, 16'h0000, 16'h0000, 1'b0};
        vecs[4]  = '{1'b1, 3'd0, 16'h0001, 16'h0000, 1'b0}; // EN with LOAD=0
        vecs[5]  = '{1'b0, 3'd0, 16'h0000, 16'h0000, 1'b0}; // refused
        vecs[6]  = '{1'b1, 3'd0, 16'h0007, 16'h0000, 1'b0};
        vecs[7]  = '{1'b0, 3'd0, 16'h0000, 16'h0006, 1'b0}; // IE/MODE update, EN=0
        vecs[8]  = '{1'b1, 3'd2, 16'hFFA5, 16'h0000, 1'b0};
        vecs[9]  = '{1'b0, 3'd2, 16'h0000, 16'h00A5, 1'b0};
        vecs[10] = '{1'b1, 3'd1, 16'hBEEF, 16'h0000, 1'b1};
        vecs[11] = '{1'b0, 3'd1, 16'h0000, 16'hBEEF, 1'b0};
        vecs[12] = '{1'b1, 3'd4, 16'h1234, 16'h0000, 1'b0};
        vecs[13] = '{1'b0, 3'd4, 16'h0000, 16'h0000, 1'b0};
        vecs[14] = '{1'b1, 3'd5, 16'hFFFF, 16'h0000, 1'b0};
        vecs[15] = '{1'b0, 3'd5, 16'h0000, 16'h0000, 1'b0};
        vecs[16] = '{1'b0, 3'd6, 16'h0000, 16'h0000, 1'b0};
        vecs[17] = '{1'b0, 3'd7, 16'h0000, 16'h0000, 1'b0};
        vecs[18] = '{1'b1, 3'd3, 16'hFFFE, 16'h0000, 1'b0};
        vecs[19] = '{1'b0, 3'd3, 16'h0000, 16'h0000, 1'b0};
        vecs[20] = '{1'b1, 3'd0, 16'h0000, 16'h0000, 1'b0};
        vecs[21] = '{1'b0, 3'd0, 16'h0000, 16'h0000, 1'b0};

        // ---------- reset state + register table ----------
        do_reset();
        check("rst_irq", 32'(irq), 32'd0);
        check("rst_cnt_ce", 32'(cnt_ce), 32'd0);
        check("rst_cnt_we", 32'(cnt_we), 32'd0);
        for (int v = 0; v < NV; v++) begin
            wr_en   = vecs[v].wr;
            addr    = vecs[v].addr;
            wr_data = vecs[v].data;
            #1;
            if (vecs[v].wr) begin
                check($sformatf("vec%0d_we", v), 32'(cnt_we), 32'(vecs[v].exp_we));
                check($sformatf("vec%0d_din", v), 32'(cnt_din), 32'(vecs[v].data));
            end else begin
                check($sformatf("vec%0d_rd", v), 32'(rd_data), 32'(vecs[v].exp_rd));
            end
            check($sformatf("vec%0d_ce", v), 32'(cnt_ce), 32'd0);
            check($sformatf("vec%0d_irq", v), 32'(irq), 32'd0);
            $display("vec %0d wr=%0b addr=%0d data=%h rd=%h", v, vecs[v].wr, vecs[v].addr, vecs[v].data, rd_data);
            step();
            wr_en = 1'b0;
        end

        // ---------- periodic: LOAD=3, PRESC=0, IE=1 ----------
        do_reset();
        do_wr(3'd1, 16'd3);
        do_wr(3'd0, 16'h0005);   // now in cycle T+1
        for (int k = 1; k <= 14; k++) begin
            if (k == 9) begin
                wr_en = 1'b1; addr = 3'd3; wr_data = 16'h0001;
                #1;
            end else begin
                wr_en = 1'b0;
                rd_chk($sformatf("per_count_k%0d", k), 3'd4, 16'((k - 1) % 4));
            end
            check($sformatf("per_ce_k%0d", k), 32'(cnt_ce), 32'd1);
            check($sformatf("per_irq_k%0d", k), 32'(irq),
                  32'(((k >= 5) && (k <= 9)) || (k >= 13)));
            $display("periodic cycle T+%0d ce=%0b irq=%0b", k, cnt_ce, irq);
            step();
        end
        wr_en = 1'b0;

        // ---------- one-shot: LOAD=2, PRESC=1 ----------
        do_reset();
        do_wr(3'd1, 16'd2);
        do_wr(3'd2, 16'd1);
        do_wr(3'd0, 16'h0003);   // now in cycle T+1
        for (int k = 1; k <= 9; k++) begin
            check($sformatf("os_ce_k%0d", k), 32'(cnt_ce), 32'((k == 2) || (k == 4)));
            rd_chk($sformatf("os_ctrl_k%0d", k), 3'd0, (k <= 5) ? 16'h0003 : 16'h0002);
            rd_chk($sformatf("os_status_k%0d", k), 3'd3, (k <= 5) ? 16'h0002 : 16'h0001);
            check($sformatf("os_irq_k%0d", k), 32'(irq), 32'd0);
            $display("oneshot cycle T+%0d ce=%0b ctrl=%h", k, cnt_ce, rd_data);
            step();
        end

        // ---------- LOAD write blocked while running ----------
        do_reset();
        do_wr(3'd1, 16'd5);
        do_wr(3'd0, 16'h0001);
        wr_en = 1'b1; addr = 3'd1; wr_data = 16'd7;
        #1;
        check("ldrun_we", 32'(cnt_we), 32'd0);
        step();
        wr_en = 1'b0;
        rd_chk("ldrun_load", 3'd1, 16'd5);
        $display("load while running: load=%h", rd_data);
        step();
        do_wr(3'd0, 16'h0000);
        wr_en = 1'b1; addr = 3'd1; wr_data = 16'd7;
        #1;
        check("ldidle_we", 32'(cnt_we), 32'd1);
        check("ldidle_din", 32'(cnt_din), 32'd7);
        step();
        wr_en = 1'b0;
        #1;
        check("ldidle_we_drop", 32'(cnt_we), 32'd0);
        rd_chk("ldidle_load", 3'd1, 16'd7);
        $display("load while idle: load=%h", rd_data);

        // ---------- clear collides with overflow event ----------
        do_reset();
        do_wr(3'd1, 16'd3);
        do_wr(3'd0, 16'h0005);   // T+1
        repeat (3) step();       // T+4: event cycle
        wr_en = 1'b1; addr = 3'd3; wr_data = 16'h0001;
        step();                  // T+5
        wr_en = 1'b0;
        check("clr_evt_irq", 32'(irq), 32'd1);
        rd_chk("clr_evt_status", 3'd3, 16'h0003);
        $display("clear+event: status=%h", rd_data);
        step();                  // T+6: no event
        wr_en = 1'b1; addr = 3'd3; wr_data = 16'h0001;
        step();                  // T+7
        wr_en = 1'b0;
        check("clr_irq", 32'(irq), 32'd0);
        rd_chk("clr_status", 3'd3, 16'h0002);
        $display("clear alone: status=%h", rd_data);

        // ---------- async reset mid-run ----------
        do_reset();
        do_wr(3'd1, 16'd2);
        do_wr(3'd0, 16'h0005);
        for (int i = 0; i < 50; i++) begin
            if (irq) break;
            step();
        end
        check("arst_pre_irq", 32'(irq), 32'd1);
        check("arst_pre_ce", 32'(cnt_ce), 32'd1);
        #2;
        rstn = 1'b0;
        #1;
        check("arst_irq", 32'(irq), 32'd0);
        check("arst_ce", 32'(cnt_ce), 32'd0);
        rd_chk("arst_ctrl", 3'd0, 16'h0000);
        rd_chk("arst_load", 3'd1, 16'h0000);
        rd_chk("arst_presc", 3'd2, 16'h0000);
        $display("async reset applied mid-run");
        step();
        rstn = 1'b1;
        for (int k = 0; k < 4; k++) begin
            check($sformatf("arst_post_ce%0d", k), 32'(cnt_ce), 32'd0);
            rd_chk($sformatf("arst_post_status%0d", k), 3'd3, 16'h0000);
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
